twiddle_gen: RTL

TWIDDLE_GEN -- requirements
Module: twiddle_gen

---
 rtl/twiddle_gen_pkg.sv | 18 +
 rtl/twiddle_gen_if.sv | 33 +++
 rtl/twiddle_gen_rom.sv | 71 +++++++
 rtl/twiddle_gen.sv | 107 ++++++++++
 4 files changed

// File: rtl/twiddle_gen_pkg.sv
// rtl/twiddle_gen_pkg.sv - shared types and defaults for the twiddle generator
// Purpose: FSM state encoding, default FFT size / twiddle width, and the
//          default quarter-wave cosine table (N=16, 8-bit signed).
// Ports:   none (package).
package twiddle_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_N_LOG2 = 4;
  localparam int DEF_TW     = 8;

  // Q(cos(2*pi*i/16)) for i = 0..4, full-scale 127.
  localparam logic signed [7:0] DEF_QCOS [5] = '{8'sd127, 8'sd117, 8'sd90, 8'sd49, 8'sd0};

endpackage

// File: rtl/twiddle_gen_if.sv
// rtl/twiddle_gen_if.sv - request/stream bundle between a requester and twiddle_gen
// Purpose: groups the start/stage request, busy status and the valid/ready
//          twiddle output stream.
// Ports:   start, stage, out_ready (requester -> generator);
//          busy, twdl_r, twdl_i, tw_index, out_valid, out_last (generator -> requester).
interface twiddle_gen_if
  import twiddle_pkg::*;
#(
  parameter int N_LOG2        = DEF_N_LOG2,
  parameter int twiddle_width = DEF_TW
) ();

  logic                            start;
  logic [$clog2(N_LOG2)-1:0]       stage;
  logic                            busy;
  logic signed [twiddle_width-1:0] twdl_r;
  logic signed [twiddle_width-1:0] twdl_i;
  logic [N_LOG2-2:0]               tw_index;
  logic                            out_valid;
  logic                            out_ready;
  logic                            out_last;

  modport master (
    output start, stage, out_ready,
    input  busy, twdl_r, twdl_i, tw_index, out_valid, out_last
  );

  modport slave (
    input  start, stage, out_ready,
    output busy, twdl_r, twdl_i, tw_index, out_valid, out_last
  );

endinterface

// File: rtl/twiddle_gen_rom.sv
// rtl/twiddle_gen_rom.sv - combinational exponent-to-twiddle lookup
// Purpose: maps exponent k (0..N/2-1) to (cos, -sin) of 2*pi*k/N using only a
//          quarter-wave cosine table of N/4+1 entries and quadrant symmetry.
// Ports:   k_i  - exponent k
//          re_o - Q(cos(2*pi*k/N))
//          im_o - Q(-sin(2*pi*k/N))
module twiddle_rom
  import twiddle_pkg::*;
#(
  parameter int N_LOG2        = DEF_N_LOG2,
  parameter int twiddle_width = DEF_TW
) (
  input  logic [N_LOG2-2:0]               k_i,
  output logic signed [twiddle_width-1:0] re_o,
  output logic signed [twiddle_width-1:0] im_o
);

  localparam int KW = N_LOG2 - 1;
  localparam int Q  = 1 << (N_LOG2 - 2);
  localparam logic [KW-1:0] QK = KW'(Q);

  // Table entry i = Q(cos(2*pi*i/N)); the default geometry uses the package
  // table, other geometries evaluate a cosine series at elaboration.
  function automatic logic signed [twiddle_width-1:0] qcos_entry(input int i);
    real x;
    real term;
    real sum;
    real v;
    if (N_LOG2 == DEF_N_LOG2 && twiddle_width == DEF_TW)
      return twiddle_width'(DEF_QCOS[i]);
    x    = 6.283185307179586 * real'(i) / real'(1 << N_LOG2);
    sum  = 1.0;
    term = 1.0;
    for (int n = 1; n <= 14; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    v = sum * real'((1 << (twiddle_width - 1)) - 1);
    if (v < 0.0) v = 0.0;
    return twiddle_width'($rtoi(v + 0.5));
  endfunction

  logic signed [twiddle_width-1:0] qtab [Q+1];

  for (genvar gi = 0; gi <= Q; gi++) begin : g_tab
    localparam logic signed [twiddle_width-1:0] VAL = qcos_entry(gi);
    assign qtab[gi] = VAL;
  end

  logic [KW-1:0] idx_re;
  logic [KW-1:0] idx_im;
  logic          neg_re;

  // k <= N/4: cos = T[k], sin = T[N/4-k].
  // k >  N/4: cos = -T[N/2-k], sin = T[k-N/4]. N/2-k equals -k in KW bits.
  always_comb begin
    idx_re = k_i;
    idx_im = QK - k_i;
    neg_re = 1'b0;
    if (k_i > QK) begin
      idx_re = '0 - k_i;
      idx_im = k_i - QK;
      neg_re = 1'b1;
    end
  end

  // Table magnitudes never exceed 2^(tw-1)-1, so negation cannot overflow.
  assign re_o = neg_re ? -qtab[idx_re] : qtab[idx_re];
  assign im_o = -qtab[idx_im];

endmodule

// File: rtl/twiddle_gen.sv
// rtl/twiddle_gen.sv - streams one FFT stage's DIF twiddle factors
// Purpose: on start, emits N/2 factors W^k, k = (j mod (N>>(s+1))) << s,
//          over a valid/ready stream with registered outputs.
// Ports:   clk   - clock, rising edge
//          rst_n - synchronous active-low reset
//          tw_if - slave side of twiddle_gen_if (request, busy, factor stream)
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int N_LOG2        = DEF_N_LOG2,
  parameter int twiddle_width = DEF_TW
) (
  input  logic         clk,
  input  logic         rst_n,
  twiddle_gen_if.slave tw_if
);

  localparam int KW = N_LOG2 - 1;
  localparam int SW = $clog2(N_LOG2);
  localparam logic [SW:0]   NL     = (SW + 1)'(N_LOG2);
  localparam logic [KW-1:0] LAST_J = '1;

  state_e                          state_q;
  logic [KW-1:0]                   j_q, j_d;
  logic [SW-1:0]                   s_q, s_clamp, s_use;
  logic                            valid_q, last_q;
  logic [KW-1:0]                   idx_q, k_d;
  logic signed [twiddle_width-1:0] re_q, im_q, re_d, im_d;
  logic                            accept, advance;

  assign accept  = (state_q == ST_IDLE) && tw_if.start;
  assign advance = (state_q == ST_RUN) && valid_q && tw_if.out_ready;
  assign s_clamp = ({1'b0, tw_if.stage} >= NL) ? SW'(N_LOG2 - 1) : tw_if.stage;
  assign s_use   = accept ? s_clamp : s_q;

  always_comb begin
    j_d = j_q;
    if (accept)       j_d = '0;
    else if (advance) j_d = j_q + 1'b1;
  end

  // Shifting j left by s and truncating to KW bits equals
  // (j mod 2^(KW-s)) << s, i.e. the DIF exponent.
  assign k_d = j_d << s_use;

  twiddle_rom #(
    .N_LOG2        (N_LOG2),
    .twiddle_width (twiddle_width)
  ) u_rom (
    .k_i  (k_d),
    .re_o (re_d),
    .im_o (im_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tw_if.start) begin
            state_q <= ST_RUN;
            j_q     <= j_d;
            s_q     <= s_clamp;
            valid_q <= 1'b1;
            last_q  <= (j_d == LAST_J);
            idx_q   <= k_d;
            re_q    <= re_d;
            im_q    <= im_d;
          end
        end
        ST_RUN: begin
          if (advance) begin
            if (last_q) begin
              state_q <= ST_IDLE;
              j_q     <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              j_q    <= j_d;
              last_q <= (j_d == LAST_J);
              idx_q  <= k_d;
              re_q   <= re_d;
              im_q   <= im_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tw_if.busy      = (state_q == ST_RUN);
  assign tw_if.out_valid = valid_q;
  assign tw_if.out_last  = last_q;
  assign tw_if.tw_index  = idx_q;
  assign tw_if.twdl_r    = re_q;
  assign tw_if.twdl_i    = im_q;

endmodule
